// File: rtl/frame_draw_sequencer_if.sv
// Bundle between the frame sequencer, its three drawing clients and the VGA adapter.
// The sequencer takes the master side.
interface frame_draw_sequencer_if #(
  parameter int unsigned COLOUR_W = 3
);
  logic                frame_tick;
  logic                map_redraw_req;
  logic [8:0]          map_x;
  logic [7:0]          map_y;
  logic [COLOUR_W-1:0] map_colour;
  logic                map_write;
  logic                map_done;
  logic [8:0]          hud_x;
  logic [7:0]          hud_y;
  logic [COLOUR_W-1:0] hud_colour;
  logic                hud_write;
  logic                hud_done;
  logic [8:0]          spr_x;
  logic [7:0]          spr_y;
  logic [COLOUR_W-1:0] spr_colour;
  logic                spr_write;
  logic                spr_done;
  logic                map_enable;
  logic                hud_enable;
  logic                spr_enable;
  logic [8:0]          vga_x;
  logic [7:0]          vga_y;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_plot;
  logic                frame_busy;
  logic [7:0]          frame_count;
  logic                overrun;
  logic                timeout_err;

  modport master (
    input  frame_tick, map_redraw_req,
    input  map_x, map_y, map_colour, map_write, map_done,
    input  hud_x, hud_y, hud_colour, hud_write, hud_done,
    input  spr_x, spr_y, spr_colour, spr_write, spr_done,
    output map_enable, hud_enable, spr_enable,
    output vga_x, vga_y, vga_colour, vga_plot,
    output frame_busy, frame_count, overrun, timeout_err
  );

  modport slave (
    output frame_tick, map_redraw_req,
    output map_x, map_y, map_colour, map_write, map_done,
    output hud_x, hud_y, hud_colour, hud_write, hud_done,
    output spr_x, spr_y, spr_colour, spr_write, spr_done,
    input  map_enable, hud_enable, spr_enable,
    input  vga_x, vga_y, vga_colour, vga_plot,
    input  frame_busy, frame_count, overrun, timeout_err
  );
endinterface

// File: rtl/frame_draw_sequencer.sv
// Per-frame sequencer: map (when dirty), HUD, then sprites, each guarded by a watchdog,
// with the active client's pixel stream registered onto the single VGA write port.
module frame_draw_sequencer #(
  parameter int unsigned COLOUR_W       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned TMO_W          = 17
) (
  input logic                   clock,
  input logic                   reset,
  frame_draw_sequencer_if.master bus
);
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMap  = 3'd1;
  localparam logic [2:0] StGapM = 3'd2;
  localparam logic [2:0] StHud  = 3'd3;
  localparam logic [2:0] StGapH = 3'd4;
  localparam logic [2:0] StSpr  = 3'd5;
  localparam logic [2:0] StGapS = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                map_dirty_q, map_dirty_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic [8:0]          vga_x_q, vga_x_d;
  logic [7:0]          vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;

  logic in_phase, phase_done, wdog_hit, phase_exit;

  always_comb begin
    in_phase   = (state_q == StMap) || (state_q == StHud) || (state_q == StSpr);
    phase_done = 1'b0;
    case (state_q)
      StMap:   phase_done = bus.map_done;
      StHud:   phase_done = bus.hud_done;
      StSpr:   phase_done = bus.spr_done;
      default: phase_done = 1'b0;
    endcase
    wdog_hit   = (wdog_q == TMO_W'(TIMEOUT_CYCLES - 1));
    phase_exit = in_phase && (phase_done || wdog_hit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.frame_tick) state_d = map_dirty_q ? StMap : StHud;
      StMap:   if (phase_exit) state_d = StGapM;
      StGapM:  state_d = StHud;
      StHud:   if (phase_exit) state_d = StGapH;
      StGapH:  state_d = StSpr;
      StSpr:   if (phase_exit) state_d = StGapS;
      StGapS:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Non-phase states park the watchdog at zero, so every phase entry starts from 0.
    wdog_d        = in_phase ? wdog_q + TMO_W'(1) : '0;
    timeout_err_d = timeout_err_q | (phase_exit & ~phase_done);
    map_dirty_d   = bus.map_redraw_req | (map_dirty_q & ~((state_q == StMap) & phase_exit));
    frame_count_d = (state_q == StGapS) ? frame_count_q + 8'd1 : frame_count_q;
    overrun_d     = overrun_q | (bus.frame_tick & (state_q != StIdle));
  end

  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    case (state_q)
      StMap: begin
        vga_x_d      = bus.map_x;
        vga_y_d      = bus.map_y;
        vga_colour_d = bus.map_colour;
        vga_plot_d   = bus.map_write;
      end
      StHud: begin
        vga_x_d      = bus.hud_x;
        vga_y_d      = bus.hud_y;
        vga_colour_d = bus.hud_colour;
        vga_plot_d   = bus.hud_write;
      end
      StSpr: begin
        vga_x_d      = bus.spr_x;
        vga_y_d      = bus.spr_y;
        vga_colour_d = bus.spr_colour;
        vga_plot_d   = bus.spr_write;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      wdog_q        <= '0;
      map_dirty_q   <= 1'b1;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_plot_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      map_dirty_q   <= map_dirty_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      vga_x_q       <= vga_x_d;
      vga_y_q       <= vga_y_d;
      vga_colour_q  <= vga_colour_d;
      vga_plot_q    <= vga_plot_d;
    end
  end

  assign bus.map_enable  = (state_q == StMap);
  assign bus.hud_enable  = (state_q == StHud);
  assign bus.spr_enable  = (state_q == StSpr);
  assign bus.frame_busy  = (state_q != StIdle);
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.vga_plot    = vga_plot_q;
endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: a short-timeout instance driven from a frame table, directed
// corner sequences, and a randomized run against a schedule-queue reference model.
module tb_frame_draw_sequencer;
  localparam int CW    = 3;
  localparam int TO_M  = 64;
  localparam int TO_T  = 16;
  localparam int PIDLE = 0;
  localparam int PMAP  = 1;
  localparam int PHUD  = 2;
  localparam int PSPR  = 3;
  localparam int PGAP  = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  frame_draw_sequencer_if #(.COLOUR_W(CW)) ifc ();
  frame_draw_sequencer_if #(.COLOUR_W(CW)) ift ();

  frame_draw_sequencer #(.COLOUR_W(CW), .TIMEOUT_CYCLES(TO_M), .TMO_W(7)) dut (
    .clock(clock), .reset(reset), .bus(ifc)
  );
  frame_draw_sequencer #(.COLOUR_W(CW), .TIMEOUT_CYCLES(TO_T), .TMO_W(5)) dut_t (
    .clock(clock), .reset(reset), .bus(ift)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Client behaviour: done rises once the enable has been high for more than dly cycles.
  bit auto_m = 1'b1;
  int m_cnt, h_cnt, s_cnt, m_dly, h_dly, s_dly;
  int tm_cnt, th_cnt, ts_cnt, tm_dly, th_dly, ts_dly;

  task automatic cyc();
    @(posedge clock);
    #1;
    cycle++;
    if (auto_m) begin
      m_cnt = ifc.map_enable ? m_cnt + 1 : 0;
      h_cnt = ifc.hud_enable ? h_cnt + 1 : 0;
      s_cnt = ifc.spr_enable ? s_cnt + 1 : 0;
      ifc.map_done = ifc.map_enable && (m_cnt > m_dly);
      ifc.hud_done = ifc.hud_enable && (h_cnt > h_dly);
      ifc.spr_done = ifc.spr_enable && (s_cnt > s_dly);
    end
    tm_cnt = ift.map_enable ? tm_cnt + 1 : 0;
    th_cnt = ift.hud_enable ? th_cnt + 1 : 0;
    ts_cnt = ift.spr_enable ? ts_cnt + 1 : 0;
    ift.map_done = ift.map_enable && (tm_cnt > tm_dly);
    ift.hud_done = ift.hud_enable && (th_cnt > th_dly);
    ift.spr_done = ift.spr_enable && (ts_cnt > ts_dly);
  endtask

  task automatic clear_inputs();
    ifc.frame_tick = 0; ifc.map_redraw_req = 0;
    ifc.map_x = 0; ifc.map_y = 0; ifc.map_colour = 0; ifc.map_write = 0; ifc.map_done = 0;
    ifc.hud_x = 0; ifc.hud_y = 0; ifc.hud_colour = 0; ifc.hud_write = 0; ifc.hud_done = 0;
    ifc.spr_x = 0; ifc.spr_y = 0; ifc.spr_colour = 0; ifc.spr_write = 0; ifc.spr_done = 0;
    ift.frame_tick = 0; ift.map_redraw_req = 0;
    ift.map_x = 0; ift.map_y = 0; ift.map_colour = 0; ift.map_write = 0; ift.map_done = 0;
    ift.hud_x = 0; ift.hud_y = 0; ift.hud_colour = 0; ift.hud_write = 0; ift.hud_done = 0;
    ift.spr_x = 0; ift.spr_y = 0; ift.spr_colour = 0; ift.spr_write = 0; ift.spr_done = 0;
  endtask

  int m_first, m_last, h_first, h_last, s_first, s_last, m_len, h_len, s_len;

  // Observe the main instance from the current cycle until frame_busy drops.
  task automatic watch_frame();
    m_first = -1; h_first = -1; s_first = -1; m_last = -1; h_last = -1; s_last = -1;
    m_len = 0; h_len = 0; s_len = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ifc.frame_busy) return;
      if (ifc.map_enable) begin if (m_first < 0) m_first = cycle; m_last = cycle; m_len++; end
      if (ifc.hud_enable) begin if (h_first < 0) h_first = cycle; h_last = cycle; h_len++; end
      if (ifc.spr_enable) begin if (s_first < 0) s_first = cycle; s_last = cycle; s_len++; end
      cyc();
    end
    chk("frame_end_bound", ifc.frame_busy, 0);
  endtask

  task automatic tick_main();
    ifc.frame_tick = 1; cyc(); ifc.frame_tick = 0;
  endtask

  typedef struct {
    bit req; int dm; int dh; int ds;
    int e_map; int e_hud; int e_spr; bit e_tmo; int e_fc;
  } vec_t;
  vec_t tbl [5];

  typedef struct { int ph; bit done; bit last; bit tmo; bit fend; } ent_t;
  ent_t sq[$];
  bit   md_dirty, md_ovr, md_tmo, md_plot;
  logic [8:0]    md_x;
  logic [7:0]    md_y, md_fc;
  logic [CW-1:0] md_c;

  task automatic add_phase(input int ph, input int k);
    ent_t e;
    int   len = (k < TO_M) ? k + 1 : TO_M;
    for (int i = 0; i < len; i++) begin
      e.ph = ph; e.done = (i >= k); e.last = (i == len - 1);
      e.tmo = e.last && (k >= TO_M); e.fend = 0;
      sq.push_back(e);
    end
  endtask

  task automatic add_gap(input bit fend);
    ent_t e;
    e.ph = PGAP; e.done = 0; e.last = 0; e.tmo = 0; e.fend = fend;
    sq.push_back(e);
  endtask

  function automatic int rand_k();
    return ($urandom_range(0, 15) == 0) ? TO_M + int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, 8));
  endfunction

  initial begin
    int lm, lh, ls, lb, fc0, busy_cnt;
    tbl[0] = '{0, 3,  2,  1,  4,  3,  2,  0, 1};
    tbl[1] = '{0, 0,  5,  5,  0,  6,  6,  0, 2};
    tbl[2] = '{1, 15, 0,  0,  16, 1,  1,  0, 3};
    tbl[3] = '{0, 0,  99, 2,  0,  16, 3,  1, 4};
    tbl[4] = '{1, 99, 1,  99, 16, 2,  16, 1, 5};

    clear_inputs();
    m_dly = 0; h_dly = 0; s_dly = 0; tm_dly = 0; th_dly = 0; ts_dly = 0;
    m_cnt = 0; h_cnt = 0; s_cnt = 0; tm_cnt = 0; th_cnt = 0; ts_cnt = 0;
    reset = 1; cyc(); cyc();
    chk("rst_enables", {ifc.map_enable, ifc.hud_enable, ifc.spr_enable}, 0);
    chk("rst_busy", ifc.frame_busy, 0);
    chk("rst_count", ifc.frame_count, 0);
    chk("rst_flags", {ifc.overrun, ifc.timeout_err}, 0);
    chk("rst_vga", {ifc.vga_x, ifc.vga_y, ifc.vga_colour, ifc.vga_plot}, 0);
    chk("rst_t_enables", {ift.map_enable, ift.hud_enable, ift.spr_enable, ift.frame_busy}, 0);
    reset = 0;

    // Frame table on the 16-cycle-timeout instance.
    for (int i = 0; i < 5; i++) begin
      tm_dly = tbl[i].dm; th_dly = tbl[i].dh; ts_dly = tbl[i].ds;
      if (tbl[i].req) begin ift.map_redraw_req = 1; cyc(); ift.map_redraw_req = 0; end
      ift.frame_tick = 1; cyc(); ift.frame_tick = 0;
      lm = 0; lh = 0; ls = 0; lb = 0;
      for (int j = 0; j < 200 && ift.frame_busy; j++) begin
        lm += int'(ift.map_enable); lh += int'(ift.hud_enable); ls += int'(ift.spr_enable);
        lb++;
        cyc();
      end
      chk($sformatf("tbl%0d_map_len", i), lm, tbl[i].e_map);
      chk($sformatf("tbl%0d_hud_len", i), lh, tbl[i].e_hud);
      chk($sformatf("tbl%0d_spr_len", i), ls, tbl[i].e_spr);
      chk($sformatf("tbl%0d_busy_len", i), lb,
          tbl[i].e_map + tbl[i].e_hud + tbl[i].e_spr + ((tbl[i].e_map > 0) ? 3 : 2));
      chk($sformatf("tbl%0d_timeout_err", i), ift.timeout_err, tbl[i].e_tmo);
      chk($sformatf("tbl%0d_frame_count", i), ift.frame_count, tbl[i].e_fc);
      cyc();
    end

    // Directed: first frame with map, tick at cycle 10.
    reset = 1; cyc(); reset = 0; cycle = 0;
    m_dly = 20; h_dly = 5; s_dly = 5;
    while (cycle < 10) cyc();
    tick_main();
    watch_frame();
    chk("a_map_first", m_first, 11);
    chk("a_map_last", m_last, 31);
    chk("a_hud_first", h_first, 33);
    chk("a_hud_len", h_len, 6);
    chk("a_spr_first", s_first, 40);
    chk("a_spr_len", s_len, 6);
    chk("a_idle_cycle", cycle, 47);
    chk("a_frame_count", ifc.frame_count, 1);

    // Second frame: map no longer dirty.
    cyc(); cyc();
    tick_main();
    chk("b_hud_first_cycle", {ifc.map_enable, ifc.hud_enable}, 2'b01);
    watch_frame();
    chk("b_map_len", m_len, 0);
    chk("b_frame_count", ifc.frame_count, 2);

    // Mux latency and filtering, then redraw request coincident with the map exit.
    ifc.map_redraw_req = 1; cyc(); ifc.map_redraw_req = 0; cyc();
    m_dly = 4;
    tick_main();
    chk("c_in_map", ifc.map_enable, 1);
    ifc.map_write = 1; ifc.map_x = 175; ifc.map_y = 10; ifc.map_colour = 5;
    ifc.hud_write = 1; ifc.hud_x = 7;   ifc.hud_y = 7;  ifc.hud_colour = 2;
    cyc();
    chk("c_vga_pixel", {ifc.vga_x, ifc.vga_y, ifc.vga_colour, ifc.vga_plot},
        {9'd175, 8'd10, 3'd5, 1'b1});
    ifc.map_write = 0;
    cyc();
    chk("c_foreign_write_blocked", ifc.vga_plot, 0);
    ifc.hud_write = 0;
    for (int i = 0; i < 20 && !ifc.map_done; i++) cyc();
    chk("e_map_done_seen", ifc.map_done, 1);
    ifc.map_redraw_req = 1; cyc(); ifc.map_redraw_req = 0;
    chk("e_map_exited", ifc.map_enable, 0);
    watch_frame();
    cyc();
    tick_main();
    chk("e_redraw_kept", ifc.map_enable, 1);
    watch_frame();
    chk("e_frame_count", ifc.frame_count, 4);
    chk("e_no_overrun_yet", ifc.overrun, 0);

    // Tick during SPR is dropped and flagged.
    cyc();
    tick_main();
    for (int i = 0; i < 100 && !ifc.spr_enable; i++) cyc();
    chk("d_spr_reached", ifc.spr_enable, 1);
    tick_main();
    watch_frame();
    chk("d_overrun", ifc.overrun, 1);
    chk("d_frame_count", ifc.frame_count, 5);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin busy_cnt += int'(ifc.frame_busy); cyc(); end
    chk("d_no_extra_frame", busy_cnt, 0);

    // Reset in the middle of HUD.
    h_dly = 30;
    tick_main();
    for (int i = 0; i < 100 && !ifc.hud_enable; i++) cyc();
    chk("f_hud_reached", ifc.hud_enable, 1);
    ifc.hud_write = 1; ifc.hud_x = 33;
    cyc();
    chk("f_hud_plot", {ifc.vga_x, ifc.vga_plot}, {9'd33, 1'b1});
    reset = 1; cyc(); reset = 0;
    ifc.hud_write = 0;
    chk("f_enables_after_reset", {ifc.map_enable, ifc.hud_enable, ifc.spr_enable}, 0);
    chk("f_busy_after_reset", ifc.frame_busy, 0);
    chk("f_plot_after_reset", ifc.vga_plot, 0);

    // Randomized run against the schedule model.
    auto_m = 0;
    clear_inputs();
    reset = 1; cyc(); reset = 0;
    md_dirty = 1; md_ovr = 0; md_tmo = 0; md_plot = 0; md_x = 0; md_y = 0; md_c = 0; md_fc = 0;
    sq.delete();
    for (int n = 0; n < 3000; n++) begin
      int   cur;
      ent_t e;
      cur = (sq.size() > 0) ? sq[0].ph : PIDLE;
      chk("rnd_enables", {ifc.map_enable, ifc.hud_enable, ifc.spr_enable},
          {cur == PMAP, cur == PHUD, cur == PSPR});
      chk("rnd_busy", ifc.frame_busy, cur != PIDLE);
      chk("rnd_frame_count", ifc.frame_count, md_fc);
      chk("rnd_flags", {ifc.overrun, ifc.timeout_err}, {md_ovr, md_tmo});
      chk("rnd_vga", {ifc.vga_x, ifc.vga_y, ifc.vga_colour, ifc.vga_plot},
          {md_x, md_y, md_c, md_plot});

      ifc.frame_tick     = (cur == PIDLE) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 49) == 0);
      ifc.map_redraw_req = ($urandom_range(0, 39) == 0);
      ifc.map_x = 9'($urandom_range(0, 511)); ifc.map_y = 8'($urandom_range(0, 255));
      ifc.hud_x = 9'($urandom_range(0, 511)); ifc.hud_y = 8'($urandom_range(0, 255));
      ifc.spr_x = 9'($urandom_range(0, 511)); ifc.spr_y = 8'($urandom_range(0, 255));
      ifc.map_colour = CW'($urandom_range(0, 7));
      ifc.hud_colour = CW'($urandom_range(0, 7));
      ifc.spr_colour = CW'($urandom_range(0, 7));
      ifc.map_write = 1'($urandom_range(0, 1));
      ifc.hud_write = 1'($urandom_range(0, 1));
      ifc.spr_write = 1'($urandom_range(0, 1));
      ifc.map_done = (cur == PMAP) && sq[0].done;
      ifc.hud_done = (cur == PHUD) && sq[0].done;
      ifc.spr_done = (cur == PSPR) && sq[0].done;

      md_plot = 0;
      if (cur == PMAP) begin
        md_x = ifc.map_x; md_y = ifc.map_y; md_c = ifc.map_colour; md_plot = ifc.map_write;
      end else if (cur == PHUD) begin
        md_x = ifc.hud_x; md_y = ifc.hud_y; md_c = ifc.hud_colour; md_plot = ifc.hud_write;
      end else if (cur == PSPR) begin
        md_x = ifc.spr_x; md_y = ifc.spr_y; md_c = ifc.spr_colour; md_plot = ifc.spr_write;
      end
      if (sq.size() == 0) begin
        if (ifc.frame_tick) begin
          if (md_dirty) begin add_phase(PMAP, rand_k()); add_gap(0); end
          add_phase(PHUD, rand_k()); add_gap(0);
          add_phase(PSPR, rand_k()); add_gap(1);
        end
      end else begin
        e = sq.pop_front();
        if (ifc.frame_tick) md_ovr = 1;
        if (e.tmo) md_tmo = 1;
        if (e.ph == PMAP && e.last) md_dirty = 0;
        if (e.fend) md_fc = md_fc + 8'd1;
      end
      if (ifc.map_redraw_req) md_dirty = 1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
